// File: rtl/bidirectional_spi_responder_pkg.sv
// Shared types and helpers for the 3-wire half-duplex SPI responder.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, WAIT_CS} resp_state_e;

  localparam logic RW_READ = 1'b1;

  // Classify a detected sclk edge as {sample, shift} for the given mode.
  function automatic logic [1:0] edge_class(input logic cpol, input logic cpha, input logic rising);
    logic sample;
    sample = (rising ^ cpol) ^ cpha;
    return {sample, ~sample};
  endfunction

endpackage

// File: rtl/bidirectional_spi_responder_sync.sv
// 2-flop synchronizer for the SPI pins plus one history flop on the low EDGE_W bits
// for edge detection.
module spi_pin_synchronizer #(
  parameter int WIDTH  = 3,
  parameter int EDGE_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WIDTH-1:0]  async_i,
  output logic [WIDTH-1:0]  sync_o,
  output logic [EDGE_W-1:0] rise_o,
  output logic [EDGE_W-1:0] fall_o
);

  logic [WIDTH-1:0]  meta_q, sync_q;
  logic [EDGE_W-1:0] hist_q;

  // Reset to 0 so a chip select already low at reset release is never seen as a fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      hist_q <= sync_q[EDGE_W-1:0];
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q[EDGE_W-1:0] & ~hist_q;
  assign fall_o = ~sync_q[EDGE_W-1:0] & hist_q;

endmodule

// File: rtl/bidirectional_spi_responder.sv
// SPI target on a single shared sdio wire: oversamples the bus in fabric_clk, decodes
// {RW, ADDR, DATA} frames and bridges them onto a simple register bus.
module bidirectional_spi_responder
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  fabric_clk,
  input  logic                  reset_n,
  input  logic                  spi_cpol,
  input  logic                  spi_cpha,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  inout  wire                   spi_sdio,
  output logic                  spi_sdio_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr_en,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  frame_done,
  output logic                  frame_error
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [2:0] pins_s;
  logic [1:0] rise_s, fall_s;

  spi_pin_synchronizer #(.WIDTH(3), .EDGE_W(2)) u_sync (
    .clk_i  (fabric_clk),
    .rst_ni (reset_n),
    .async_i({spi_sdio, spi_cs_n, spi_sclk}),
    .sync_o (pins_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  logic sclk_s, cs_s, sdio_s, sclk_edge, cs_rise, cs_fall;
  assign sclk_s    = pins_s[0];
  assign cs_s      = pins_s[1];
  assign sdio_s    = pins_s[2];
  assign sclk_edge = rise_s[0] | fall_s[0];
  assign cs_rise   = rise_s[1];
  assign cs_fall   = fall_s[1];

  logic [1:0] cls;
  logic       sample_ev, shift_ev, last_bit;
  // On a detected edge the synced level already shows the direction it went.
  assign cls       = edge_class(spi_cpol, spi_cpha, sclk_s);
  assign sample_ev = sclk_edge & ~cs_s & cls[1];
  assign shift_ev  = sclk_edge & ~cs_s & cls[0];

  resp_state_e           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  rw_q, oe_q, wr_en_q, rd_en_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, tx_q;

  assign last_bit = (cnt_q == CNT_W'(1));

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tx_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      // Chip select release mid-frame beats any sclk edge seen in the same cycle.
      if (cs_rise && (state_q inside {CMD, ADDR, WDATA, RDATA})) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        err_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (cs_fall) begin
            state_q <= CMD;
            cnt_q   <= '0;
          end
          CMD: if (sample_ev) begin
            rw_q    <= sdio_s;
            cnt_q   <= CNT_W'(ADDR_WIDTH);
            state_q <= ADDR;
          end
          ADDR: if (sample_ev) begin
            addr_q <= {addr_q[ADDR_WIDTH-2:0], sdio_s};
            cnt_q  <= cnt_q - CNT_W'(1);
            if (last_bit) begin
              cnt_q <= CNT_W'(DATA_WIDTH);
              if (rw_q == RW_READ) begin
                rd_en_q <= 1'b1;
                state_q <= RDATA;
              end else begin
                state_q <= WDATA;
              end
            end
          end
          WDATA: if (sample_ev) begin
            wdata_q <= {wdata_q[DATA_WIDTH-2:0], sdio_s};
            cnt_q   <= cnt_q - CNT_W'(1);
            if (last_bit) begin
              wr_en_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= WAIT_CS;
            end
          end
          RDATA: begin
            if (rd_en_q) tx_q <= reg_rd_data;
            if (sample_ev && cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
              // With CPHA=1 no shift edge follows the last sample inside the frame.
              if (last_bit && spi_cpha) begin
                oe_q    <= 1'b0;
                done_q  <= 1'b1;
                state_q <= WAIT_CS;
              end
            end else if (shift_ev) begin
              if (!oe_q) begin
                oe_q <= 1'b1;
              end else if (cnt_q == '0) begin
                oe_q    <= 1'b0;
                done_q  <= 1'b1;
                state_q <= WAIT_CS;
              end else begin
                tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
          WAIT_CS: if (cs_rise) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi_sdio    = oe_q ? tx_q[DATA_WIDTH-1] : 1'bz;
  assign spi_sdio_oe = oe_q;
  assign reg_addr    = addr_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_data = wdata_q;
  assign reg_rd_en   = rd_en_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_bidirectional_spi_responder.sv
// Directed + randomized bench: a behavioural SPI master drives frames, a register-bank
// model answers reads, and results are compared against an expected memory image.
module tb_bidirectional_spi_responder;

  localparam int AW = 7, DW = 16, CLK = 10, HP = 60;

  logic fabric_clk = 1'b0, reset_n = 1'b0;
  logic spi_cpol = 1'b0, spi_cpha = 1'b0, spi_sclk = 1'b0, spi_cs_n = 1'b1;
  logic m_oe = 1'b0, m_out = 1'b0;
  wire  spi_sdio;
  logic          spi_sdio_oe, reg_wr_en, reg_rd_en, frame_done, frame_error;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wr_data, reg_rd_data;

  logic          use_forced = 1'b0;
  logic [DW-1:0] forced_rd = '0;
  logic [DW-1:0] bank [128];
  logic [DW-1:0] exp_mem [128];
  logic [AW-1:0] wq [$];

  int n_wr = 0, n_rd = 0, n_done = 0, n_err = 0, n_oe = 0;
  int s_wr, s_rd, s_done, s_err, s_oe;
  logic [AW-1:0] last_wa = '0;
  logic [DW-1:0] last_wd = '0;
  int n_assert = 0, n_fail = 0;

  assign spi_sdio    = m_oe ? m_out : 1'bz;
  assign reg_rd_data = use_forced ? forced_rd : bank[reg_addr];

  always #(CLK/2) fabric_clk = ~fabric_clk;

  bidirectional_spi_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .fabric_clk (fabric_clk),
    .reset_n    (reset_n),
    .spi_cpol   (spi_cpol),
    .spi_cpha   (spi_cpha),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_sdio   (spi_sdio),
    .spi_sdio_oe(spi_sdio_oe),
    .reg_addr   (reg_addr),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_data(reg_wr_data),
    .reg_rd_en  (reg_rd_en),
    .reg_rd_data(reg_rd_data),
    .frame_done (frame_done),
    .frame_error(frame_error)
  );

  // Register bank and event counters, sampled away from the active edge.
  always @(negedge fabric_clk) begin
    if (reg_wr_en) begin
      bank[reg_addr] <= reg_wr_data;
      last_wa        <= reg_addr;
      last_wd        <= reg_wr_data;
      n_wr           <= n_wr + 1;
    end
    if (reg_rd_en)   n_rd   <= n_rd + 1;
    if (frame_done)  n_done <= n_done + 1;
    if (frame_error) n_err  <= n_err + 1;
    if (spi_sdio_oe) n_oe   <= n_oe + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_wr = n_wr; s_rd = n_rd; s_done = n_done; s_err = n_err; s_oe = n_oe;
  endtask

  // Behavioural master: nbits clocks of frame {rw,addr,data}, optional extra clocks,
  // optional reset pulse after bit rst_bit.
  task automatic xfer(input logic cpol, input logic cpha, input logic rw,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int nbits, input int extra, input int rst_bit,
                      output logic [DW-1:0] rx, output logic oe_end,
                      output logic oe_x, output logic rst_outs);
    logic [23:0] fr;
    fr = {rw, a, d};
    rx = '0; oe_x = 1'b0; rst_outs = 1'b0;
    spi_cpol = cpol; spi_cpha = cpha; spi_sclk = cpol;
    #(4*CLK);
    spi_cs_n = 1'b0;
    #(HP);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        m_oe = (i < 8) || !rw; m_out = fr[23-i];
        #(HP);
        if (rw && i >= 8) rx = {rx[DW-2:0], spi_sdio};
        spi_sclk = ~cpol;
        #(HP);
        spi_sclk = cpol;
      end else begin
        spi_sclk = ~cpol;
        m_oe = (i < 8) || !rw; m_out = fr[23-i];
        #(HP);
        if (rw && i >= 8) rx = {rx[DW-2:0], spi_sdio};
        spi_sclk = cpol;
        #(HP);
      end
      if (i == rst_bit) begin
        reset_n = 1'b0;
        #(3*CLK);
        rst_outs = spi_sdio_oe | reg_wr_en | reg_rd_en | frame_done | frame_error |
                   (|reg_addr) | (|reg_wr_data);
        reset_n = 1'b1;
      end
    end
    if (!cpha) #(HP);
    for (int e = 0; e < extra; e++) begin
      spi_sclk = ~cpol; #(HP); oe_x |= spi_sdio_oe;
      spi_sclk = cpol;  #(HP); oe_x |= spi_sdio_oe;
    end
    oe_end = spi_sdio_oe;
    m_oe = 1'b0;
    spi_cs_n = 1'b1;
    #(8*CLK);
  endtask

  // Complete frame: writes update the expected image, reads must return exp_rd.
  task automatic run_frame(input string tag, input logic cpol, input logic cpha, input logic rw,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input int extra,
                           input logic [DW-1:0] exp_rd);
    logic [DW-1:0] rx;
    logic oe_end, oe_x, ro;
    snap();
    xfer(cpol, cpha, rw, a, d, 24, extra, -1, rx, oe_end, oe_x, ro);
    chk({tag, "_done"},   n_done - s_done, 1);
    chk({tag, "_err"},    n_err - s_err, 0);
    chk({tag, "_oe_end"}, oe_end, 0);
    chk({tag, "_oe_x"},   oe_x, 0);
    chk({tag, "_addr"},   reg_addr, a);
    if (rw) begin
      chk({tag, "_rd_en"}, n_rd - s_rd, 1);
      chk({tag, "_wr_en"}, n_wr - s_wr, 0);
      chk({tag, "_rdata"}, rx, exp_rd);
    end else begin
      chk({tag, "_wr_en"}, n_wr - s_wr, 1);
      chk({tag, "_rd_en"}, n_rd - s_rd, 0);
      chk({tag, "_wa"},    last_wa, a);
      chk({tag, "_wd"},    last_wd, d);
      chk({tag, "_oe"},    n_oe - s_oe, 0);
      exp_mem[a] = d;
      wq.push_back(a);
    end
  endtask

  initial begin
    logic [DW-1:0] rx, d3;
    logic [AW-1:0] a3, a4;
    logic oe_end, oe_x, ro;

    #22;
    chk("reset_oe", spi_sdio_oe, 0);
    chk("reset_outs", {reg_wr_en, reg_rd_en, frame_done, frame_error, reg_addr, reg_wr_data}, 0);
    #5;
    reset_n = 1'b1;
    #(4*CLK);

    run_frame("t1_m0_wr", 1'b0, 1'b0, 1'b0, 7'h15, 16'hBEEF, 0, 16'h0);

    use_forced = 1'b1; forced_rd = 16'hA5C3;
    run_frame("t2_m3_rd", 1'b1, 1'b1, 1'b1, 7'h02, 16'h0, 0, 16'hA5C3);
    use_forced = 1'b0;

    a3 = 7'($urandom_range(0, 127));
    d3 = 16'($urandom);
    run_frame("t3_m1_wr", 1'b0, 1'b1, 1'b0, a3, d3, 0, 16'h0);
    run_frame("t3_m2_rd", 1'b1, 1'b0, 1'b1, a3, 16'h0, 0, exp_mem[a3]);

    a4 = a3 ^ 7'h40;
    snap();
    xfer(1'b0, 1'b0, 1'b0, a4, 16'h1234, 18, 0, -1, rx, oe_end, oe_x, ro);
    chk("t4_err",   n_err - s_err, 1);
    chk("t4_wr_en", n_wr - s_wr, 0);
    chk("t4_done",  n_done - s_done, 0);
    chk("t4_oe",    n_oe - s_oe, 0);
    run_frame("t4_next", 1'b0, 1'b0, 1'b1, a3, 16'h0, 0, exp_mem[a3]);

    run_frame("t5_extra", 1'b0, 1'b0, 1'b1, 7'h15, 16'h0, 40, exp_mem[7'h15]);

    snap();
    xfer(1'b1, 1'b0, 1'b1, 7'h15, 16'h0, 24, 0, 14, rx, oe_end, oe_x, ro);
    chk("t6_rst_outs", ro, 0);
    chk("t6_oe_end",   oe_end, 0);
    chk("t6_done",     n_done - s_done, 0);
    chk("t6_err",      n_err - s_err, 0);
    run_frame("t6_next", 1'b1, 1'b1, 1'b1, a3, 16'h0, 0, exp_mem[a3]);

    for (int k = 0; k < 8; k++) begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      logic [1:0]    md;
      logic          rrw;
      md  = 2'($urandom_range(0, 3));
      rrw = ($urandom_range(0, 1) == 1);
      rd  = 16'($urandom);
      if (rrw) ra = wq[$urandom_range(0, wq.size() - 1)];
      else     ra = 7'($urandom_range(0, 127));
      run_frame("rnd", md[1], md[0], rrw, ra, rd, 0, exp_mem[ra]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
